// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory stage: RV32I load/store width codes,
// memory-stage FSM state encoding and width classification helpers.
package rv_mem_pkg;

    // RV32I funct3 codes for loads and stores
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Memory-stage FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } mem_width_e;

    // Access width implied by funct3; unknown codes are treated as word
    // (they are rejected as illegal before they reach the bus anyway).
    function automatic mem_width_e f3_width(input logic [2:0] f3);
        mem_width_e w;
        case (f3)
            F3_B, F3_BU: w = W_BYTE;
            F3_H, F3_HU: w = W_HALF;
            default:     w = W_WORD;
        endcase
        return w;
    endfunction

    // Loads accept signed and unsigned widths; stores only B/H/W.
    function automatic logic f3_legal(input logic st, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~st;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the load/store unit: byte-enable generation,
// store-data lane replication, load shift/extension and access checking.
module lsu_align
    import rv_mem_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        illegal,
    output logic        misaligned
);

    mem_width_e  width_s;
    logic [15:0] sh_s;

    // Classify width and detect illegal or misaligned accesses
    always_comb begin
        width_s    = f3_width(funct3);
        illegal    = ~f3_legal(is_store, funct3);
        misaligned = 1'b0;
        case (width_s)
            W_BYTE:  misaligned = 1'b0;
            W_HALF:  misaligned = addr_lo[0];
            W_WORD:  misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    end

    // Byte lanes touched and store data replicated across every lane
    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        case (width_s)
            W_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            W_HALF: begin
                if (addr_lo[1]) begin
                    be = 4'b1100;
                end else begin
                    be = 4'b0011;
                end
                wdata_rep = {2{wdata[15:0]}};
            end
            W_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0000_0000;
            end
        endcase
    end

    // Low 16 bits of the read word shifted down by the byte offset
    always_comb begin
        case (addr_lo)
            2'd0:    sh_s = bus_rdata[15:0];
            2'd1:    sh_s = bus_rdata[23:8];
            2'd2:    sh_s = bus_rdata[31:16];
            2'd3:    sh_s = {8'h00, bus_rdata[31:24]};
            default: sh_s = 16'h0000;
        endcase
    end

    // Sign or zero extension of the selected sub-word
    always_comb begin
        case (funct3)
            F3_B:    rdata_ext = {{24{sh_s[7]}}, sh_s[7:0]};
            F3_BU:   rdata_ext = {24'h00_0000, sh_s[7:0]};
            F3_H:    rdata_ext = {{16{sh_s[15]}}, sh_s};
            F3_HU:   rdata_ext = {16'h0000, sh_s};
            F3_W:    rdata_ext = bus_rdata;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store from the control unit, runs a single
// word-bus transaction with timeout, and returns aligned/extended load data.
module load_store_unit
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter value of the final REQ cycle before giving up on the bus
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic        is_store_r;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;
    logic [15:0] tmo_cnt_r;
    logic        tmo_hit_s;

    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] rdata_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_be_r;
    logic [31:0] bus_wdata_r;

    logic        al_is_store_s;
    logic [2:0]  al_funct3_s;
    logic [1:0]  al_addr_lo_s;
    logic [3:0]  al_be_s;
    logic [31:0] al_wdata_s;
    logic [31:0] al_rdata_s;
    logic        al_illegal_s;
    logic        al_misaligned_s;
    logic        access_err_s;

    // The aligner checks the live request in IDLE and extracts load data from latched fields afterwards
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_is_store_s = is_store;
            al_funct3_s   = funct3;
            al_addr_lo_s  = addr[1:0];
        end else begin
            al_is_store_s = is_store_r;
            al_funct3_s   = funct3_r;
            al_addr_lo_s  = addr_lo_r;
        end
    end

    lsu_align u_align (
        .is_store   (al_is_store_s),
        .funct3     (al_funct3_s),
        .addr_lo    (al_addr_lo_s),
        .wdata      (wdata),
        .bus_rdata  (bus_rdata),
        .be         (al_be_s),
        .wdata_rep  (al_wdata_s),
        .rdata_ext  (al_rdata_s),
        .illegal    (al_illegal_s),
        .misaligned (al_misaligned_s)
    );

    assign access_err_s = al_illegal_s | al_misaligned_s;
    assign tmo_hit_s    = (tmo_cnt_r == TMO_LAST);

    // Next-state logic; an ack in the timeout cycle still completes normally
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (access_err_s) begin
                        state_next_s = ST_ERR;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    state_next_s = ST_DONE;
                end else if (tmo_hit_s) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            ST_ERR:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture the fields needed later for load extraction
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_r <= 1'b0;
            funct3_r   <= 3'd0;
            addr_lo_r  <= 2'd0;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            is_store_r <= is_store;
            funct3_r   <= funct3;
            addr_lo_r  <= addr[1:0];
        end else begin
            is_store_r <= is_store_r;
            funct3_r   <= funct3_r;
            addr_lo_r  <= addr_lo_r;
        end
    end

    // Count REQ cycles spent waiting for the bus; cleared outside REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_REQ) && (state_next_s == ST_REQ)) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= 16'd0;
        end
    end

    // Bus request fields, loaded on entry to REQ and held stable until it ends
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && (state_next_s == ST_REQ)) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= is_store;
            bus_addr_r  <= {addr[31:2], 2'b00};
            bus_be_r    <= al_be_s;
            bus_wdata_r <= al_wdata_s;
        end else if ((state_r == ST_REQ) && (state_next_s != ST_REQ)) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= bus_addr_r;
            bus_be_r    <= bus_be_r;
            bus_wdata_r <= bus_wdata_r;
        end else begin
            bus_req_r   <= bus_req_r;
            bus_we_r    <= bus_we_r;
            bus_addr_r  <= bus_addr_r;
            bus_be_r    <= bus_be_r;
            bus_wdata_r <= bus_wdata_r;
        end
    end

    // Response pulse and load data; an error response always returns zero
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            rdata_r      <= 32'h0000_0000;
        end else begin
            resp_valid_r <= (state_next_s == ST_DONE) || (state_next_s == ST_ERR);
            resp_err_r   <= (state_next_s == ST_ERR);
            if (state_next_s == ST_ERR) begin
                rdata_r <= 32'h0000_0000;
            end else if ((state_r == ST_REQ) && bus_ack) begin
                rdata_r <= al_rdata_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign stall      = ((state_r == ST_IDLE) && req_valid) || (state_r == ST_REQ);
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign rdata      = rdata_r;
    assign bus_req    = bus_req_r;
    assign bus_we     = bus_we_r;
    assign bus_addr   = bus_addr_r;
    assign bus_be     = bus_be_r;
    assign bus_wdata  = bus_wdata_r;

endmodule
